// File: rtl/hc_sr04_ranger.sv
// HC-SR04 ultrasonic ranger: issues the TRIG pulse, times the ECHO high width
// in clk ticks and reports it with a one-cycle valid or timeout strobe.
module hc_sr04_ranger #(
  parameter int unsigned TRIG_CYCLES    = 500,
  parameter int unsigned TIMEOUT_CYCLES = 1900000,
  parameter int unsigned PERIOD_CYCLES  = 3000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        echo_in,
  output logic        trig_out,
  output logic [20:0] ticks_20ns,
  output logic        valid,
  output logic        timeout,
  output logic        busy
);

  localparam int unsigned TRIG_W = $clog2(TRIG_CYCLES + 1);
  localparam int unsigned PER_W  = $clog2(PERIOD_CYCLES + 1);

  localparam logic [TRIG_W-1:0] TRIG_LAST = TRIG_W'(TRIG_CYCLES - 1);
  localparam logic [20:0]       TO_MAX    = 21'(TIMEOUT_CYCLES);
  localparam logic [20:0]       TO_LAST   = 21'(TIMEOUT_CYCLES - 1);
  localparam logic [PER_W-1:0]  PER_MAX   = PER_W'(PERIOD_CYCLES);
  // HOLDOFF->IDLE->TRIG costs two cycles, so leave HOLDOFF two counts early
  // to land trigger starts exactly PERIOD_CYCLES apart.
  localparam logic [PER_W-1:0]  PER_EXIT  = PER_W'(PERIOD_CYCLES - 2);

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    HOLDOFF
  } state_t;

  state_t            state_q, state_d;
  logic [TRIG_W-1:0] trig_cnt_q, trig_cnt_d;
  logic [20:0]       wait_cnt_q, wait_cnt_d;
  logic [20:0]       cnt_q, cnt_d;
  logic [PER_W-1:0]  period_q, period_d;
  logic [20:0]       ticks_q, ticks_d;
  logic              trig_q, trig_d;
  logic              valid_q, valid_d;
  logic              timeout_q, timeout_d;

  logic echo_meta_q, echo_s_q, echo_d_q;
  logic echo_rise, echo_fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      echo_meta_q <= 1'b0;
      echo_s_q    <= 1'b0;
      echo_d_q    <= 1'b0;
    end else begin
      echo_meta_q <= echo_in;
      echo_s_q    <= echo_meta_q;
      echo_d_q    <= echo_s_q;
    end
  end

  assign echo_rise = echo_s_q & ~echo_d_q;
  assign echo_fall = ~echo_s_q & echo_d_q;

  always_comb begin
    state_d    = state_q;
    trig_cnt_d = trig_cnt_q;
    wait_cnt_d = wait_cnt_q;
    cnt_d      = cnt_q;
    ticks_d    = ticks_q;
    valid_d    = 1'b0;
    timeout_d  = 1'b0;
    period_d   = (period_q == PER_MAX) ? period_q : period_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d    = TRIG;
          trig_cnt_d = '0;
          period_d   = '0;
        end
      end
      TRIG: begin
        if (trig_cnt_q == TRIG_LAST) begin
          state_d    = WAIT_RISE;
          wait_cnt_d = '0;
        end else begin
          trig_cnt_d = trig_cnt_q + 1'b1;
        end
      end
      WAIT_RISE: begin
        if (echo_rise) begin
          cnt_d   = 21'd1;
          state_d = MEASURE;
        end else if (wait_cnt_q == TO_LAST) begin
          timeout_d = 1'b1;
          state_d   = HOLDOFF;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      MEASURE: begin
        if (echo_fall) begin
          ticks_d = cnt_q;
          valid_d = 1'b1;
          state_d = HOLDOFF;
        end else if (echo_s_q && (cnt_q == TO_MAX)) begin
          timeout_d = 1'b1;
          state_d   = HOLDOFF;
        end else if (echo_s_q) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLDOFF: begin
        // A stuck-high echo keeps us here so the sensor is never re-triggered mid-echo.
        if ((period_q >= PER_EXIT) && !echo_s_q) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    trig_d = (state_d == TRIG);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      trig_cnt_q <= '0;
      wait_cnt_q <= '0;
      cnt_q      <= '0;
      period_q   <= '0;
      ticks_q    <= '0;
      trig_q     <= 1'b0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      trig_cnt_q <= trig_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      ticks_q    <= ticks_d;
      trig_q     <= trig_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
    end
  end

  assign trig_out   = trig_q;
  assign ticks_20ns = ticks_q;
  assign valid      = valid_q;
  assign timeout    = timeout_q;
  assign busy       = (state_q != IDLE);

endmodule
